// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared helpers for the XNOR Fibonacci LFSR generators.
//   LFSR_MAX_W        widest supported LFSR state
//   LFSR_LEGAL_WIDTHS state widths that have a maximal-length tap set
//   lfsr_width_legal  true when a width is listed in LFSR_LEGAL_WIDTHS
//   lfsr_taps         tap mask (bit i = 1-based tap i+1) for a legal width
//   lfsr_next         one XNOR-feedback shift step; the register length is
//                     taken from the highest tap present in the mask
package lfsr_pkg;

  localparam int unsigned LFSR_MAX_W = 32;

  // Element 0 is the narrowest width.
  localparam logic [3:0][7:0] LFSR_LEGAL_WIDTHS = {8'd32, 8'd24, 8'd16, 8'd8};

  function automatic logic lfsr_width_legal(input int unsigned width);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (32'(LFSR_LEGAL_WIDTHS[i]) == width) begin
        ok = 1'b1;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned width);
    logic [LFSR_MAX_W-1:0] mask;
    case (width)
      32'd8:   mask = 32'h0000_00B8;  // taps 8,6,5,4
      32'd16:  mask = 32'h0000_D008;  // taps 16,15,13,4
      32'd24:  mask = 32'h00E1_0000;  // taps 24,23,22,17
      32'd32:  mask = 32'h8020_0003;  // taps 32,22,2,1
      default: mask = 32'h0000_0000;
    endcase
    return mask;
  endfunction

  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] state,
                                                      input logic [LFSR_MAX_W-1:0] mask);
    logic [LFSR_MAX_W-1:0] keep;
    logic                  fb;
    // A bit belongs to the register when some tap sits at or above it.
    for (int i = 0; i < 32; i++) begin
      keep[i] = |(mask >> i);
    end
    fb = ~^(state & mask);
    return ((state << 1) | {31'h0, fb}) & keep;
  endfunction

endpackage

// File: rtl/lfsr_range_map.sv
// lfsr_range_map: maps a uniform OUT_W-bit value onto [min_i, max_i] with a
// multiply-high (no division, no modulo bias beyond the truncation).
//   r_i      raw random value
//   min_i    inclusive lower bound
//   max_i    inclusive upper bound; max_i < min_i collapses the range to min_i
//   value_o  min_i + (r_i * span) >> OUT_W, truncated to OUT_W bits
module lfsr_range_map #(
  parameter int unsigned OUT_W = 8
) (
  input  logic [OUT_W-1:0] r_i,
  input  logic [OUT_W-1:0] min_i,
  input  logic [OUT_W-1:0] max_i,
  output logic [OUT_W-1:0] value_o
);

  logic [OUT_W:0]   span_s;
  logic [2*OUT_W:0] prod_s;

  // Span needs one extra bit so the full range (2^OUT_W) is representable.
  always_comb begin
    span_s = (OUT_W+1)'(1'b1);
    if (max_i < min_i) begin
      span_s = (OUT_W+1)'(1'b1);
    end else begin
      span_s = {1'b0, max_i} - {1'b0, min_i} + (OUT_W+1)'(1'b1);
    end
    prod_s  = (2*OUT_W+1)'(r_i) * (2*OUT_W+1)'(span_s);
    value_o = OUT_W'({1'b0, min_i} + prod_s[2*OUT_W:OUT_W]);
  end

endmodule

// File: rtl/lfsr_rand_gen.sv
// lfsr_rand_gen: XNOR Fibonacci LFSR feeding a one-entry valid/ready output
// register with runtime seeding, lockup recovery and range mapping.
//   clk, rst      clock, asynchronous active-high reset
//   seed_load_i   load seed_i (discards any pending value)
//   seed_i        new LFSR state; all-ones is replaced by SEED_DEFAULT
//   min_i, max_i  inclusive output range, sampled when a new value loads
//   rand_valid_o  rand_o/state_o hold an unconsumed value
//   rand_ready_i  consumer takes rand_o this cycle
//   rand_o        range-mapped value derived from state_o
//   state_o       LFSR state behind rand_o
//   lockup_o      one-cycle pulse when an all-ones state was replaced
module lfsr_rand_gen
  import lfsr_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned OUT_W        = 8,
  parameter logic [31:0] SEED_DEFAULT = 32'hAE1F_B42C
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic [OUT_W-1:0] min_i,
  input  logic [OUT_W-1:0] max_i,
  output logic             rand_valid_o,
  input  logic             rand_ready_i,
  output logic [OUT_W-1:0] rand_o,
  output logic [WIDTH-1:0] state_o,
  output logic             lockup_o
);

  localparam logic [WIDTH-1:0]      SEED_W   = WIDTH'(SEED_DEFAULT);
  localparam logic [LFSR_MAX_W-1:0] TAP_MASK = lfsr_taps(WIDTH);

  if (!lfsr_width_legal(WIDTH)) begin : g_bad_width
    $error("lfsr_rand_gen: WIDTH must be 8, 16, 24 or 32");
  end
  if ((OUT_W < 1) || (OUT_W > WIDTH)) begin : g_bad_out_w
    $error("lfsr_rand_gen: OUT_W must lie in 1..WIDTH");
  end
  if (SEED_W == {WIDTH{1'b1}}) begin : g_bad_seed
    $error("lfsr_rand_gen: SEED_DEFAULT must not be all-ones");
  end

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] state_out_r;
  logic [OUT_W-1:0] rand_r;
  logic             valid_r;
  logic             lockup_r;
  logic [WIDTH-1:0] nxt_s;
  logic             load_s;
  logic [OUT_W-1:0] mapped_s;

  // Next LFSR state and output-register load enable.
  always_comb begin
    nxt_s  = WIDTH'(lfsr_next(32'(state_r), TAP_MASK));
    load_s = !valid_r || rand_ready_i;
  end

  lfsr_range_map #(
    .OUT_W (OUT_W)
  ) u_map (
    .r_i     (nxt_s[WIDTH-1 -: OUT_W]),
    .min_i   (min_i),
    .max_i   (max_i),
    .value_o (mapped_s)
  );

  // LFSR state, output register and lockup pulse; seed load beats recovery beats load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= SEED_W;
      state_out_r <= '0;
      rand_r      <= '0;
      valid_r     <= 1'b0;
      lockup_r    <= 1'b0;
    end else begin
      lockup_r <= 1'b0;
      if (seed_load_i) begin
        valid_r <= 1'b0;
        if (&seed_i) begin
          state_r  <= SEED_W;
          lockup_r <= 1'b1;
        end else begin
          state_r <= seed_i;
        end
      end else if (&state_r) begin
        // XNOR LFSRs stick at all-ones; reseed and keep the output as is.
        state_r  <= SEED_W;
        lockup_r <= 1'b1;
      end else if (load_s) begin
        state_r     <= nxt_s;
        state_out_r <= nxt_s;
        rand_r      <= mapped_s;
        valid_r     <= 1'b1;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign rand_valid_o = valid_r;
  assign rand_o       = rand_r;
  assign state_o      = state_out_r;
  assign lockup_o     = lockup_r;

endmodule

// File: tb/tb_lfsr_rand_gen.sv
// tb_lfsr_rand_gen: directed checks of lfsr_rand_gen (WIDTH=32 and WIDTH=8).
module tb_lfsr_rand_gen;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        seed_load;
  logic [31:0] seed;
  logic [7:0]  min_v;
  logic [7:0]  max_v;
  logic        ready;
  logic        valid;
  logic [7:0]  rand_v;
  logic [31:0] state_v;
  logic        lockup;

  logic        seed_load8;
  logic [7:0]  seed8;
  logic [7:0]  min8;
  logic [7:0]  max8;
  logic        ready8;
  logic        valid8;
  logic [7:0]  rand8;
  logic [7:0]  state8;
  logic        lockup8;

  int total_cnt = 0;
  int pass_cnt  = 0;

  lfsr_rand_gen u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .seed_load_i  (seed_load),
    .seed_i       (seed),
    .min_i        (min_v),
    .max_i        (max_v),
    .rand_valid_o (valid),
    .rand_ready_i (ready),
    .rand_o       (rand_v),
    .state_o      (state_v),
    .lockup_o     (lockup)
  );

  lfsr_rand_gen #(
    .WIDTH (8),
    .OUT_W (8)
  ) u_dut8 (
    .clk          (clk),
    .rst          (rst),
    .seed_load_i  (seed_load8),
    .seed_i       (seed8),
    .min_i        (min8),
    .max_i        (max8),
    .rand_valid_o (valid8),
    .rand_ready_i (ready8),
    .rand_o       (rand8),
    .state_o      (state8),
    .lockup_o     (lockup8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    if (obs === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Independent reference: explicit tap positions 32,22,2,1 and 8,6,5,4.
  function automatic logic [31:0] ref_next32(input logic [31:0] s);
    return {s[30:0], ~(s[31] ^ s[21] ^ s[1] ^ s[0])};
  endfunction

  function automatic logic [7:0] ref_next8(input logic [7:0] s);
    return {s[6:0], ~(s[7] ^ s[5] ^ s[4] ^ s[3])};
  endfunction

  function automatic logic [7:0] ref_map(input logic [7:0] r, input logic [7:0] mn,
                                         input logic [7:0] mx);
    int span;
    int val;
    if (mx < mn) span = 1;
    else span = int'(mx) - int'(mn) + 1;
    val = int'(mn) + ((int'(r) * span) >>> 8);
    return 8'(val);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_state", state_v, 32'h0);
    check("rst_rand", {24'h0, rand_v}, 32'h0);
    check("rst_lockup", {31'h0, lockup}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    logic [7:0]  s8;
    logic [7:0]  s8_first;
    logic [9:0]  hit;
    int          errs;
    int          oor;
    int          period;
    logic        saw_ff;

    rst = 1'b0; seed_load = 1'b0; seed = 32'h0; min_v = 8'd0; max_v = 8'd255; ready = 1'b1;
    seed_load8 = 1'b0; seed8 = 8'h0; min8 = 8'd0; max8 = 8'd255; ready8 = 1'b1;
    #1;

    // Reset release, full range
    do_reset();
    @(negedge clk);
    check("first_valid", {31'h0, valid}, 32'h1);
    check("first_state", state_v, 32'h5C3F_6858);
    check("first_rand", {24'h0, rand_v}, 32'h5C);
    check("first_state8", {24'h0, state8}, 32'h59);
    check("first_rand8", {24'h0, rand8}, 32'h59);
    @(negedge clk);
    check("second_state", state_v, 32'hB87E_D0B0);
    check("second_rand", {24'h0, rand_v}, 32'hB8);
    check("second_state8", {24'h0, state8}, 32'hB3);
    @(negedge clk);
    check("third_state", state_v, 32'h70FD_A161);
    s = 32'h70FD_A161;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      s = ref_next32(s);
      if ((state_v !== s) || (rand_v !== s[31:24]) || (valid !== 1'b1)) errs++;
    end
    check("stream_1000_errs", 32'(errs), 32'h0);

    // Range [10,19]
    min_v = 8'd10; max_v = 8'd19;
    do_reset();
    @(negedge clk);
    check("map_first_10_19", {24'h0, rand_v}, 32'd13);
    s = 32'h5C3F_6858; hit = '0; oor = 0; errs = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i != 0) begin
        @(negedge clk);
        s = ref_next32(s);
      end
      if (rand_v !== ref_map(s[31:24], 8'd10, 8'd19)) errs++;
      if ((rand_v >= 8'd10) && (rand_v <= 8'd19)) hit[int'(rand_v) - 10] = 1'b1;
      else oor++;
    end
    check("map_10_19_model_errs", 32'(errs), 32'h0);
    check("map_10_19_out_of_range", 32'(oor), 32'h0);
    check("map_10_19_all_hit", {22'h0, hit}, 32'h3FF);

    // Back-pressure with min/max toggled while holding
    min_v = 8'd0; max_v = 8'd255;
    do_reset();
    @(negedge clk);
    check("bp_first_state", state_v, 32'h5C3F_6858);
    ready = 1'b0;
    errs = 0;
    for (int k = 0; k < 5; k++) begin
      min_v = 8'(k * 3 + 1);
      max_v = 8'(200 - k);
      @(negedge clk);
      if ((state_v !== 32'h5C3F_6858) || (rand_v !== 8'h5C) || (valid !== 1'b1)) errs++;
    end
    check("bp_hold_errs", 32'(errs), 32'h0);
    ready = 1'b1; min_v = 8'd0; max_v = 8'd255;
    @(negedge clk);
    check("bp_resume_state", state_v, 32'hB87E_D0B0);
    check("bp_resume_rand", {24'h0, rand_v}, 32'hB8);

    // Seed load discards the pending value
    seed_load = 1'b1; seed = 32'h0000_0001;
    @(negedge clk);
    seed_load = 1'b0;
    check("seed_valid_drop", {31'h0, valid}, 32'h0);
    check("seed_no_lockup", {31'h0, lockup}, 32'h0);
    @(negedge clk);
    check("seed_valid_back", {31'h0, valid}, 32'h1);
    check("seed_state", state_v, 32'h0000_0002);
    check("seed_rand", {24'h0, rand_v}, 32'h0);
    @(negedge clk);
    check("seed_state2", state_v, 32'h0000_0004);

    // All-ones seed triggers lockup recovery
    seed_load = 1'b1; seed = 32'hFFFF_FFFF;
    @(negedge clk);
    seed_load = 1'b0;
    check("lock_pulse", {31'h0, lockup}, 32'h1);
    check("lock_valid", {31'h0, valid}, 32'h0);
    @(negedge clk);
    check("lock_pulse_end", {31'h0, lockup}, 32'h0);
    check("lock_restart_state", state_v, 32'h5C3F_6858);
    check("lock_restart_rand", {24'h0, rand_v}, 32'h5C);

    // min == max
    min_v = 8'd42; max_v = 8'd42;
    @(negedge clk);
    check("min_eq_max_a", {24'h0, rand_v}, 32'd42);
    @(negedge clk);
    check("min_eq_max_b", {24'h0, rand_v}, 32'd42);

    // Mid-stream reset: outputs drop immediately
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'h0, valid}, 32'h0);
    check("midrst_state", state_v, 32'h0);
    @(negedge clk);
    rst = 1'b0; min_v = 8'd0; max_v = 8'd255;
    @(negedge clk);
    check("midrst_first_state", state_v, 32'h5C3F_6858);

    // WIDTH=8: period and model agreement
    @(negedge clk);
    s8_first = state8; s8 = state8; period = 0; saw_ff = 1'b0; errs = 0;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      s8 = ref_next8(s8);
      if (state8 !== s8) errs++;
      if (state8 == 8'hFF) saw_ff = 1'b1;
      if ((period == 0) && (state8 == s8_first)) period = i;
    end
    check("w8_model_errs", 32'(errs), 32'h0);
    check("w8_period", 32'(period), 32'd255);
    check("w8_no_all_ones", {31'h0, saw_ff}, 32'h0);

    // WIDTH=8: max < min collapses to min
    min8 = 8'd7; max8 = 8'd3;
    @(negedge clk);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rand8 !== 8'd7) errs++;
    end
    check("w8_inverted_range", 32'(errs), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lfsr_rand_gen.md
Name: lfsr_rand_gen

Overview:
- Synthesizable, parametrised pseudo-random source: an XNOR-feedback Fibonacci LFSR followed by a one-entry valid/ready output register.
- Maps each new state into a runtime-programmable range [min_i, max_i].
- Used as a stimulus and traffic-shaping source in benches and in on-chip BIST-style generators where there is no simulator randomization.
- Adds runtime seeding, lockup recovery and handshaked, range-mapped output.

Parameters:
- WIDTH, 32: LFSR state width; legal values 8, 16, 24, 32 (elaboration error otherwise).
- OUT_W, 8: output value width; must satisfy 1 <= OUT_W <= WIDTH.
- SEED_DEFAULT, 32'hAE1F_B42C: reset/recovery seed, truncated to WIDTH LSBs; must not be all-ones.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- seed_load_i  in  1  synchronous seed load strobe
- seed_i  in  WIDTH  seed value, sampled when seed_load_i=1
- min_i  in  OUT_W  range lower bound, inclusive
- max_i  in  OUT_W  range upper bound, inclusive
- rand_valid_o  out  1  rand_o holds a valid value
- rand_ready_i  in  1  consumer accepts rand_o
- rand_o  out  OUT_W  range-mapped random value
- state_o  out  WIDTH  LFSR state from which rand_o was derived
- lockup_o  out  1  one-cycle pulse: all-ones state detected and replaced

Behaviour:
- Reset (async assert, sync release): state=SEED_DEFAULT, rand_valid_o=0, rand_o=0, state_o=0, lockup_o=0.
- Next state: nxt = {state[WIDTH-2:0], ~^{taps}}.
- Taps (XNOR, 1-based): 8→8,6,5,4; 16→16,15,13,4; 24→24,23,22,17; 32→32,22,2,1.
- Load condition: load = !rand_valid_o || rand_ready_i (no seed_load_i in the same cycle). On load:
  - state <= nxt;
  - state_o <= nxt;
  - rand_o <= map(nxt);
  - rand_valid_o <= 1.
- The state advances only on load. When rand_valid_o=1 and rand_ready_i=0, rand_o, state_o and state are held stable.
- Latency: first rand_valid_o=1 on the first clk edge after reset release. Throughput is 1 value/cycle with rand_ready_i held high.
- Mapping:
  - r = nxt[WIDTH-1 -: OUT_W];
  - span = max_i - min_i + 1, computed in OUT_W+1 bits;
  - prod = r*span, 2*OUT_W+1 bits;
  - map = min_i + prod[2*OUT_W:OUT_W], truncated to OUT_W.
- Mapping boundaries:
  - min_i=0, max_i=all-ones gives span=2^OUT_W and map=r exactly.
  - min_i==max_i gives min_i.
  - max_i<min_i is treated as span=1, giving min_i.
- min_i/max_i are sampled only at load; a change while holding does not alter rand_o.
- Seed load (highest priority, overrides load):
  - state <= seed_i and rand_valid_o <= 0 (pending value discarded even if rand_ready_i=1 that cycle; no handshake completes).
  - The next cycle performs a normal load from the new seed.
- Lockup: if seed_i is all-ones, state <= SEED_DEFAULT and lockup_o=1 for one cycle. All-ones cannot arise otherwise, but the comparator also checks state each cycle and recovers the same way.
- Reset mid-stream: immediate return to reset values; no partial output.
- Period: 2^WIDTH-1 states. Seed all-zeros is legal.

Decomposition:
- Shared package lfsr_pkg:
  - function lfsr_taps(width), returning a WIDTH-bit tap mask;
  - constant LFSR_LEGAL_WIDTHS;
  - function lfsr_next(state, mask).
- The existing bench random function is reimplemented on lfsr_next so sim and RTL sequences match bit-for-bit.
- One sub-module: lfsr_range_map (combinational multiply-high plus min add, with the max<min guard), reused by other generators.

Test Plan:
- Reset release, WIDTH=32, OUT_W=8, min=0, max=255, ready=1 → cycle 1: valid=1, state_o=32'h5C3F_6858, rand_o=8'h5C; successive state_o equals the package reference model for 1000 values.
- Same start, min=10, max=19 → first rand_o=13; all 10000 outputs lie in [10,19] with every value hit.
- ready=0 for 5 cycles after first valid, with min/max toggled meanwhile → rand_o, state_o, state unchanged; on ready=1 the next value follows from 5C3F6858.
- seed_load_i=1, seed_i=32'h0000_0001 while valid=1 and ready=1 → next cycle valid=0; the following cycle valid=1 and state_o=lfsr_next(1).
- seed_i=32'hFFFF_FFFF load → lockup_o one-cycle pulse; stream restarts exactly as after reset (first state_o=5C3F6858).
- WIDTH=8, OUT_W=8, full range, ready=1 → state period exactly 255, all-ones never produced; max_i=3, min_i=7 → every rand_o=7.
